dl_updown_counter: RTL and testbench
====================================

DL_UPDOWN_COUNTER -- requirements
Module: dl_updown_counter

Interface
REQ-001 Parameter NUM_BITS, default 5: counter width in bits.
REQ-002 Parameter MIN_VAL, default 0: lower count bound; SHALL satisfy MIN_VAL < MAX_VAL < 2**NUM_BITS.
REQ-003 Parameter MAX_VAL, default 13: upper count bound.
REQ-004 Parameter MODE, type cnt_mode_e, default CNT_WRAP: boundary behaviour, either CNT_WRAP or CNT_SAT.
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  count enable; one step per cycle while high.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 clr  input  1  synchronous clear to MIN_VAL.
REQ-010 load  input  1  synchronous load of load_val.
REQ-011 load_val  input  NUM_BITS  value to load.
REQ-012 q  output  NUM_BITS  registered count.
REQ-013 done  output  1  combinational terminal flag: up=1 and q==MAX_VAL, or up=0 and q==MIN_VAL.
REQ-014 tc  output  1  registered one-cycle pulse, high the cycle after a counting step hits a boundary.

Function
REQ-015 Priority per cycle SHALL be clr > load > en; lower-priority requests in the same cycle are ignored.
REQ-016 clr SHALL set q to MIN_VAL next cycle and SHALL NOT assert tc.
REQ-017 load SHALL set q to load_val clamped into [MIN_VAL, MAX_VAL] next cycle, with no tc.
REQ-018 en=1 with q strictly inside the bounds SHALL move q by +1 (up=1) or -1 (up=0) next cycle; latency 1 cycle.
REQ-019 MODE=CNT_WRAP: up step from MAX_VAL SHALL give MIN_VAL; down step from MIN_VAL SHALL give MAX_VAL; tc=1 next cycle.
REQ-020 MODE=CNT_SAT: up step from MAX_VAL or down step from MIN_VAL SHALL hold q; tc=1 next cycle on every such attempted step.
REQ-021 en=0 with no clr/load SHALL hold q and drive tc=0.
REQ-022 Direction may change on any cycle; the step SHALL use the up value sampled in that cycle.
REQ-023 Arithmetic SHALL be NUM_BITS+1 wide internally; no intermediate value may alias across 0 or 2**NUM_BITS.

Reset
REQ-024 rst_n low SHALL immediately force q=MIN_VAL and tc=0, regardless of clk, even mid-count.
REQ-025 On the first edge after rst_n deasserts, the block SHALL behave as though q had just been cleared.

Configuration
REQ-026 Macro DL_UPDOWN_COUNTER_STICKY_EN, when defined, SHALL add output ovf_sticky (1 bit).
REQ-027 With the macro, ovf_sticky SHALL set on the cycle tc asserts, and clear only on clr or reset; load SHALL NOT clear it.
REQ-028 Without the macro, the port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 Package dl_counter_pkg SHALL hold typedef cnt_mode_e {CNT_WRAP, CNT_SAT}.
REQ-030 Next-value and boundary logic SHALL live in sub-module dl_counter_next_val, which is combinational and parametrised identically. The top level SHALL hold only the registers.

Verification (NUM_BITS=5, MIN_VAL=2, MAX_VAL=13 unless noted)
REQ-031 Reset, then en=1, up=1 for 12 cycles -> q runs 2..13, then 2; tc is high exactly one cycle after the 13->2 step; done=1 while q=13.
REQ-032 CNT_SAT, q=13, en=1, up=1 for 3 cycles -> q holds 13 and tc is high on each of those cycles; up=0 then steps q to 12 with tc=0.
REQ-033 Same-cycle clr=1, load=1 with load_val=9, en=1 -> q=2 next cycle; with clr=0 -> q=9; with load_val=31 -> q=13 (clamped).
REQ-034 CNT_WRAP, q=2, up=0, en=1 -> q=13 and tc=1; random toggling of en/up over 200 cycles matches a reference model cycle by cycle.
REQ-035 Drop rst_n asynchronously mid-count at q=8 -> q=2 and tc=0 before the next clk edge; counting resumes from 2 after release.
REQ-036 With DL_UPDOWN_COUNTER_STICKY_EN, after a wrap -> ovf_sticky=1; it survives load, and clears on clr.

Source files
------------

// File: rtl/dl_counter_pkg.sv
// Shared types for the dl up/down counter family.
// Boundary behaviour is selected per instance through cnt_mode_e.
package dl_counter_pkg;

    // What a counting step does when it would leave [MIN_VAL, MAX_VAL].
    typedef enum logic {
        CNT_WRAP = 1'b0,  // jump to the opposite bound
        CNT_SAT  = 1'b1   // hold at the bound
    } cnt_mode_e;

endpackage : dl_counter_pkg

// File: rtl/dl_counter_next_val.sv
// Combinational next-state logic for dl_updown_counter.
// Resolves clr > load > en priority, clamps loads into range, performs the
// +1/-1 step in NUM_BITS+1 bits and flags boundary hits (tc_next) and the
// terminal condition (done).
module dl_counter_next_val
    import dl_counter_pkg::*;
#(
    parameter int        NUM_BITS = 5,
    parameter int        MIN_VAL  = 0,
    parameter int        MAX_VAL  = 13,
    parameter cnt_mode_e MODE     = CNT_WRAP
) (
    input  logic [NUM_BITS-1:0] q,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    output logic [NUM_BITS-1:0] q_next,
    output logic                tc_next,
    output logic                done
);

    localparam int W = NUM_BITS + 1;

    localparam logic [NUM_BITS:0]   MIN_EXT = W'(MIN_VAL);
    localparam logic [NUM_BITS:0]   MAX_EXT = W'(MAX_VAL);
    localparam logic [NUM_BITS-1:0] MIN_Q   = NUM_BITS'(MIN_VAL);
    localparam logic [NUM_BITS-1:0] MAX_Q   = NUM_BITS'(MAX_VAL);

    logic [NUM_BITS:0] q_ext;
    logic [NUM_BITS:0] ld_ext;
    logic [NUM_BITS:0] step_ext;
    logic              hit;

    assign q_ext  = {1'b0, q};
    assign ld_ext = {1'b0, load_val};

    // The extra MSB keeps MAX+1 and MIN-1 distinct from in-range values:
    // an up step past MAX compares greater than MAX_EXT, and a down step
    // below 0 sets the MSB instead of aliasing to 2**NUM_BITS-1.
    assign step_ext = up ? (q_ext + W'(1)) : (q_ext - W'(1));
    assign hit      = up ? (step_ext > MAX_EXT)
                         : (step_ext[NUM_BITS] || (step_ext < MIN_EXT));

    // Terminal flag follows the live direction input, not a registered one.
    assign done = up ? (q_ext == MAX_EXT) : (q_ext == MIN_EXT);

    // Priority mux clr > load > en producing the next count and tc pulse.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        q_next  = q;
        tc_next = 1'b0;
        if (clr) begin
            q_next = MIN_Q;
        end else if (load) begin
            if (ld_ext < MIN_EXT) begin
                q_next = MIN_Q;
            end else if (ld_ext > MAX_EXT) begin
                q_next = MAX_Q;
            end else begin
                q_next = load_val;
            end
        end else if (en) begin
            if (hit) begin
                tc_next = 1'b1;
                if (MODE == CNT_WRAP) begin
                    q_next = up ? MIN_Q : MAX_Q;
                end
            end else begin
                q_next = step_ext[NUM_BITS-1:0];
            end
        end
    end

endmodule : dl_counter_next_val

// File: rtl/dl_updown_counter.sv
// Bounded up/down counter with clear, clamped load, wrap or saturate mode.
// Register-only top level; all next-state decisions live in
// dl_counter_next_val.
// Optional feature: define DL_UPDOWN_COUNTER_STICKY_EN to add ovf_sticky,
// which latches any boundary hit until clr or reset.
module dl_updown_counter
    import dl_counter_pkg::*;
#(
    parameter int        NUM_BITS = 5,
    parameter int        MIN_VAL  = 0,
    parameter int        MAX_VAL  = 13,
    parameter cnt_mode_e MODE     = CNT_WRAP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    output logic [NUM_BITS-1:0] q,
    output logic                done,
    output logic                tc
`ifdef DL_UPDOWN_COUNTER_STICKY_EN
    ,
    output logic                ovf_sticky
`endif
);

    localparam logic [NUM_BITS-1:0] MIN_Q = NUM_BITS'(MIN_VAL);

    logic [NUM_BITS-1:0] q_next;
    logic                tc_next;

    dl_counter_next_val #(
        .NUM_BITS (NUM_BITS),
        .MIN_VAL  (MIN_VAL),
        .MAX_VAL  (MAX_VAL),
        .MODE     (MODE)
    ) u_next_val (
        .q        (q),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_next   (q_next),
        .tc_next  (tc_next),
        .done     (done)
    );

    // Count and terminal-pulse registers; reset lands in the cleared state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: asynchronous reset must load the same value clr would, so the
        // first edge after release behaves exactly like the cycle after a clr.
        if (!rst_n) begin
            q  <= MIN_Q;
            tc <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers sample the
            // pre-edge values together.
            q  <= q_next;
            tc <= tc_next;
        end
    end

`ifdef DL_UPDOWN_COUNTER_STICKY_EN
    // Sticky overflow: sets alongside tc, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            ovf_sticky <= 1'b0;
        end else if (tc_next) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule : dl_updown_counter

// File: tb/tb_dl_updown_counter.sv
// Self-checking bench for dl_updown_counter (NUM_BITS=5, MIN=2, MAX=13).
// A wrap instance and a saturate instance share one stimulus stream.
module tb_dl_updown_counter;
    import dl_counter_pkg::*;

    localparam int NB   = 5;
    localparam int MINV = 2;
    localparam int MAXV = 13;
    localparam int SPAN = MAXV - MINV + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, up, clr, load;
    logic [NB-1:0] load_val;
    logic [NB-1:0] q_w, q_s;
    logic          done_w, done_s, tc_w, tc_s;
`ifdef DL_UPDOWN_COUNTER_STICKY_EN
    logic          ovf_w, ovf_s;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dl_updown_counter #(
        .NUM_BITS (NB), .MIN_VAL (MINV), .MAX_VAL (MAXV), .MODE (CNT_WRAP)
    ) dut_w (
        .clk (clk), .rst_n (rst_n), .en (en), .up (up), .clr (clr),
        .load (load), .load_val (load_val), .q (q_w), .done (done_w),
        .tc (tc_w)
`ifdef DL_UPDOWN_COUNTER_STICKY_EN
        , .ovf_sticky (ovf_w)
`endif
    );

    dl_updown_counter #(
        .NUM_BITS (NB), .MIN_VAL (MINV), .MAX_VAL (MAXV), .MODE (CNT_SAT)
    ) dut_s (
        .clk (clk), .rst_n (rst_n), .en (en), .up (up), .clr (clr),
        .load (load), .load_val (load_val), .q (q_s), .done (done_s),
        .tc (tc_s)
`ifdef DL_UPDOWN_COUNTER_STICKY_EN
        , .ovf_sticky (ovf_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic u, input logic c,
                          input logic l, input logic [NB-1:0] lv);
        en = e; up = u; clr = c; load = l; load_val = lv;
    endtask

    int m_w, m_s, e_tc_w, e_tc_s;

    initial begin
        rst_n = 1'b0;
        set_in(0, 1, 0, 0, '0);

        // Reset state, asserted from time 0.
        #12;
        check("rst_q_w", 32'(q_w), MINV);
        check("rst_tc_w", 32'(tc_w), 0);
        check("rst_q_s", 32'(q_s), MINV);
`ifdef DL_UPDOWN_COUNTER_STICKY_EN
        check("rst_ovf", 32'(ovf_w), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Twelve up steps: 3..13 then wrap to 2 (sat holds 13).
        set_in(1, 1, 0, 0, '0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("up_q_w[%0d]", k), 32'(q_w), (k < 12) ? MINV + k : MINV);
            check($sformatf("up_tc_w[%0d]", k), 32'(tc_w), (k == 12) ? 1 : 0);
            check($sformatf("up_done_w[%0d]", k), 32'(done_w), (k == 11) ? 1 : 0);
            check($sformatf("up_q_s[%0d]", k), 32'(q_s), (k < 12) ? MINV + k : MAXV);
            check($sformatf("up_tc_s[%0d]", k), 32'(tc_s), (k == 12) ? 1 : 0);
        end

        // Saturate: three more up attempts hold 13 with tc each cycle.
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("sat_q_s[%0d]", k), 32'(q_s), MAXV);
            check($sformatf("sat_tc_s[%0d]", k), 32'(tc_s), 1);
            check($sformatf("sat_q_w[%0d]", k), 32'(q_w), MINV + k);
        end
        up = 1'b0;
        step();
        check("sat_down_q_s", 32'(q_s), 12);
        check("sat_down_tc_s", 32'(tc_s), 0);
        check("sat_down_q_w", 32'(q_w), 4);

        // Priority: clr beats load beats en.
        set_in(1, 1, 1, 1, 5'd9);
        step();
        check("clr_prio_q_w", 32'(q_w), MINV);
        check("clr_prio_tc_w", 32'(tc_w), 0);
        check("clr_prio_q_s", 32'(q_s), MINV);
        set_in(1, 1, 0, 1, 5'd9);
        step();
        check("load9_q_w", 32'(q_w), 9);
        check("load9_tc_w", 32'(tc_w), 0);
        set_in(1, 1, 0, 1, 5'd31);
        step();
        check("load31_q_w", 32'(q_w), MAXV);
        check("load31_tc_w", 32'(tc_w), 0);
        set_in(0, 1, 0, 0, '0);
        step();
        check("hold_q_w", 32'(q_w), MAXV);
        check("hold_tc_w", 32'(tc_w), 0);
        set_in(1, 0, 0, 1, 5'd0);
        step();
        check("load0_q_w", 32'(q_w), MINV);
        check("load0_q_s", 32'(q_s), MINV);

        // Down step from MIN: wrap to 13, saturate holds 2; both flag tc.
        set_in(1, 0, 0, 0, '0);
        #1;
        check("done_down_w", 32'(done_w), 1);
        step();
        check("wrapdn_q_w", 32'(q_w), MAXV);
        check("wrapdn_tc_w", 32'(tc_w), 1);
        check("wrapdn_q_s", 32'(q_s), MINV);
        check("wrapdn_tc_s", 32'(tc_s), 1);

        // Random en/up against an arithmetic reference model.
        m_w = MAXV;
        m_s = MINV;
        for (int i = 0; i < 200; i++) begin
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("rnd_done_w[%0d]", i), 32'(done_w),
                  (up ? (m_w == MAXV) : (m_w == MINV)) ? 1 : 0);
            e_tc_w = 0;
            e_tc_s = 0;
            if (en) begin
                e_tc_w = (up && m_w == MAXV) || (!up && m_w == MINV);
                m_w = MINV + ((m_w - MINV + (up ? 1 : -1) + SPAN) % SPAN);
                if ((up && m_s == MAXV) || (!up && m_s == MINV)) e_tc_s = 1;
                else m_s = m_s + (up ? 1 : -1);
            end
            step();
            check($sformatf("rnd_q_w[%0d]", i), 32'(q_w), m_w);
            check($sformatf("rnd_tc_w[%0d]", i), 32'(tc_w), e_tc_w);
            check($sformatf("rnd_q_s[%0d]", i), 32'(q_s), m_s);
            check($sformatf("rnd_tc_s[%0d]", i), 32'(tc_s), e_tc_s);
        end

        // Asynchronous reset mid-count at 8, then resume from 2.
        set_in(0, 1, 0, 1, 5'd6);
        step();
        set_in(1, 1, 0, 0, '0);
        step();
        step();
        check("pre_arst_q_w", 32'(q_w), 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q_w", 32'(q_w), MINV);
        check("arst_tc_w", 32'(tc_w), 0);
        check("arst_q_s", 32'(q_s), MINV);
        #1;
        rst_n = 1'b1;
        step();
        check("resume_q_w", 32'(q_w), MINV + 1);
        check("resume_tc_w", 32'(tc_w), 0);

`ifdef DL_UPDOWN_COUNTER_STICKY_EN
        // Sticky overflow: set by wrap, survives load, cleared by clr.
        check("ovf_pre", 32'(ovf_w), 0);
        set_in(0, 1, 0, 1, 5'd13);
        step();
        set_in(1, 1, 0, 0, '0);
        step();
        check("ovf_wrap_q", 32'(q_w), MINV);
        check("ovf_set", 32'(ovf_w), 1);
        set_in(0, 1, 0, 1, 5'd5);
        step();
        check("ovf_after_load", 32'(ovf_w), 1);
        set_in(0, 1, 1, 0, '0);
        step();
        check("ovf_after_clr", 32'(ovf_w), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dl_updown_counter
